// File: rtl/vga_scan_ctrl.sv
// VGA 640x480@60 timing generator with a one-pixel registered colour/sync output stage.
// Scan coordinates go out combinationally; colour and sync come back registered together.
module vga_scan_ctrl #(
    parameter int DIV      = 4,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] d_in,
    output logic [8:0]  row,
    output logic [9:0]  col,
    output logic        rdn,
    output logic        pix_en,
    output logic        frame_start,
    output logic        hs,
    output logic        vs,
    output logic [3:0]  r,
    output logic [3:0]  g,
    output logic [3:0]  b
);

    localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DW    = $clog2(DIV);

    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
    localparam logic [DW-1:0] DIV_PRE  = DW'(DIV - 2);
    localparam logic [9:0]    H_LAST   = 10'(H_TOT - 1);
    localparam logic [9:0]    V_LAST   = 10'(V_TOT - 1);
    localparam logic [9:0]    H_VIS    = 10'(H_ACTIVE);
    localparam logic [9:0]    V_VIS    = 10'(V_ACTIVE);
    localparam logic [9:0]    HS_FIRST = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0]    HS_LAST  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [9:0]    VS_FIRST = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0]    VS_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

    logic [DW-1:0] div_cnt_q, div_cnt_d;
    logic [9:0]    h_cnt_q, h_cnt_d;
    logic [9:0]    v_cnt_q, v_cnt_d;
    logic          pix_en_q, pix_en_d;
    logic          frame_start_q, frame_start_d;
    logic          hs_q, hs_d;
    logic          vs_q, vs_d;
    logic [11:0]   rgb_q, rgb_d;

    logic active;
    logic h_end;
    logic v_end;

    assign active = (h_cnt_q < H_VIS) && (v_cnt_q < V_VIS);
    assign h_end  = (h_cnt_q == H_LAST);
    assign v_end  = (v_cnt_q == V_LAST);

    // pix_en and frame_start are registered one clk early so they line up with div_cnt == DIV-1.
    always_comb begin
        div_cnt_d     = (div_cnt_q == DIV_LAST) ? '0 : div_cnt_q + 1'b1;
        pix_en_d      = (div_cnt_q == DIV_PRE);
        frame_start_d = pix_en_d && h_end && v_end;
        h_cnt_d       = h_cnt_q;
        v_cnt_d       = v_cnt_q;
        rgb_d         = rgb_q;
        hs_d          = hs_q;
        vs_d          = vs_q;
        if (pix_en_q) begin
            if (h_end) begin
                h_cnt_d = '0;
                v_cnt_d = v_end ? '0 : v_cnt_q + 10'd1;
            end else begin
                h_cnt_d = h_cnt_q + 10'd1;
            end
            rgb_d = active ? d_in : 12'h000;
            hs_d  = ~((h_cnt_q >= HS_FIRST) && (h_cnt_q <= HS_LAST));
            vs_d  = ~((v_cnt_q >= VS_FIRST) && (v_cnt_q <= VS_LAST));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt_q     <= '0;
            h_cnt_q       <= '0;
            v_cnt_q       <= '0;
            pix_en_q      <= 1'b0;
            frame_start_q <= 1'b0;
            hs_q          <= 1'b1;
            vs_q          <= 1'b1;
            rgb_q         <= 12'h000;
        end else begin
            div_cnt_q     <= div_cnt_d;
            h_cnt_q       <= h_cnt_d;
            v_cnt_q       <= v_cnt_d;
            pix_en_q      <= pix_en_d;
            frame_start_q <= frame_start_d;
            hs_q          <= hs_d;
            vs_q          <= vs_d;
            rgb_q         <= rgb_d;
        end
    end

    assign col         = active ? h_cnt_q : 10'd0;
    assign row         = active ? v_cnt_q[8:0] : 9'd0;
    assign rdn         = ~active;
    assign pix_en      = pix_en_q;
    assign frame_start = frame_start_q;
    assign hs          = hs_q;
    assign vs          = vs_q;
    assign r           = rgb_q[11:8];
    assign g           = rgb_q[7:4];
    assign b           = rgb_q[3:0];

endmodule
